// File: rtl/multi_interrupt_controller_if.sv
// rtl/multi_interrupt_controller_if.sv - CPU-side handshake bundle for the interrupt controller
interface multi_interrupt_controller_if #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 8
);
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic               int_ack;
  logic               eoi;
  logic               int_req;
  logic               nmi_req;
  logic [VEC_W-1:0]   vector;
  logic               vector_valid;

  // CPU side: writes the mask, acknowledges and ends interrupts
  modport master (
    output mask_we, mask_wdata, int_ack, eoi,
    input  int_req, nmi_req, vector, vector_valid
  );

  // Controller side
  modport slave (
    input  mask_we, mask_wdata, int_ack, eoi,
    output int_req, nmi_req, vector, vector_valid
  );
endinterface

// File: rtl/multi_interrupt_controller.sv
// rtl/multi_interrupt_controller.sv - prioritised maskable + NMI interrupt controller with vectoring
module multi_interrupt_controller #(
  parameter int NUM_IRQ   = 8,
  parameter int VEC_W     = 8,
  parameter int VEC_BASE  = 'h20,
  parameter int NMI_VEC   = 'h02,
  parameter int EDGE_MODE = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IRQ-1:0]           irq,
  input  logic                         nmi,
  multi_interrupt_controller_if.slave  cpu,
  output logic [NUM_IRQ:0]             pending,
  output logic [NUM_IRQ:0]             in_service
);

  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_VEC,
    S_SERV
  } state_t;

  state_t             state, state_nxt;
  logic [NUM_IRQ-1:0] irq_d;
  logic               nmi_d;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ:0]   pend;
  logic [NUM_IRQ:0]   svc;
  logic               win_nmi;
  logic [IW-1:0]      win_idx;

  logic [NUM_IRQ-1:0] irq_rise;
  logic               nmi_rise;
  logic [NUM_IRQ-1:0] elig;
  logic               nmi_pend;
  logic               any_elig;
  logic [IW-1:0]      cand_idx;
  logic               latch_win;
  logic [NUM_IRQ:0]   win_bit;
  logic [NUM_IRQ:0]   pend_clr;
  logic [VEC_W-1:0]   irq_vec;

  // A line sampled low last cycle and high now is a new request; after
  // reset irq_d is zero, so a line held high through release counts once.
  assign irq_rise = irq & ~irq_d;
  assign nmi_rise = nmi & ~nmi_d;

  // NMI is never masked and always wins over the maskable lines.
  assign elig     = pend[NUM_IRQ-1:0] & ~mask;
  assign nmi_pend = pend[NUM_IRQ];
  assign any_elig = nmi_pend | (|elig);

  assign irq_vec  = VEC_W'(VEC_BASE) + VEC_W'(win_idx);

  assign pending    = pend;
  assign in_service = svc;

  // Lowest eligible index wins among maskable lines
  always_comb begin
    cand_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) cand_idx = IW'(i);
    end
  end

  // One-hot of the latched winner, used to retire pending and track service
  always_comb begin
    win_bit = '0;
    if (win_nmi) win_bit[NUM_IRQ] = 1'b1;
    else         win_bit[win_idx] = 1'b1;
    pend_clr = (state == S_VEC) ? win_bit : '0;
  end

  // Next state and Moore outputs; requests follow the live winner while in REQ
  always_comb begin
    state_nxt        = state;
    latch_win        = 1'b0;
    cpu.int_req      = 1'b0;
    cpu.nmi_req      = 1'b0;
    cpu.vector_valid = 1'b0;
    cpu.vector       = '0;
    case (state)
      S_IDLE: begin
        if (any_elig) state_nxt = S_REQ;
      end
      S_REQ: begin
        cpu.nmi_req = nmi_pend;
        cpu.int_req = ~nmi_pend & (|elig);
        if (!any_elig) begin
          state_nxt = S_IDLE;
        end else if (cpu.int_ack) begin
          latch_win = 1'b1;
          state_nxt = S_VEC;
        end
      end
      S_VEC: begin
        cpu.vector_valid = 1'b1;
        cpu.vector       = win_nmi ? VEC_W'(NMI_VEC) : irq_vec;
        state_nxt        = S_SERV;
      end
      S_SERV: begin
        if (cpu.eoi) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Input history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_d <= '0;
      nmi_d <= 1'b0;
    end else begin
      irq_d <= irq;
      nmi_d <= nmi;
    end
  end

  // Mask register; a write takes effect from the following cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           mask <= '1;
    else if (cpu.mask_we) mask <= cpu.mask_wdata;
  end

  // Winner captured on acknowledge so the vector and service bit stay stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_nmi <= 1'b0;
      win_idx <= '0;
    end else if (latch_win) begin
      win_nmi <= nmi_pend;
      win_idx <= cand_idx;
    end
  end

  // Pending: a new edge beats a same-cycle retire so no request is lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      if (EDGE_MODE != 0) pend[NUM_IRQ-1:0] <= (pend[NUM_IRQ-1:0] & ~pend_clr[NUM_IRQ-1:0]) | irq_rise;
      else                pend[NUM_IRQ-1:0] <= irq;
      pend[NUM_IRQ] <= (pend[NUM_IRQ] & ~pend_clr[NUM_IRQ]) | nmi_rise;
    end
  end

  // In-service: set when the vector goes out, cleared by end-of-interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          svc <= '0;
    else if (state == S_VEC)             svc <= svc | win_bit;
    else if (state == S_SERV && cpu.eoi) svc <= svc & ~win_bit;
  end

endmodule

// File: tb/tb_multi_interrupt_controller.sv
// tb/tb_multi_interrupt_controller.sv - scoreboard bench for the interrupt controller
module tb_multi_interrupt_controller;
  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [N-1:0] irq, irq2;
  logic         nmi, nmi2;
  logic [N:0]   pending, in_service, pending2, in_service2;

  multi_interrupt_controller_if #(.NUM_IRQ(N), .VEC_W(8)) cpu_if ();
  multi_interrupt_controller_if #(.NUM_IRQ(N), .VEC_W(8)) lvl_if ();

  multi_interrupt_controller #(
    .NUM_IRQ(N), .VEC_W(8), .VEC_BASE('h20), .NMI_VEC('h02), .EDGE_MODE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .nmi(nmi), .cpu(cpu_if),
    .pending(pending), .in_service(in_service)
  );

  multi_interrupt_controller #(
    .NUM_IRQ(N), .VEC_W(8), .VEC_BASE('hFE), .NMI_VEC('h02), .EDGE_MODE(0)
  ) dut_lvl (
    .clk(clk), .rst_n(rst_n), .irq(irq2), .nmi(nmi2), .cpu(lvl_if),
    .pending(pending2), .in_service(in_service2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: request bits per line, service bits, mask, and the
  // CPU-visible phase (0 idle, 1 requesting, 2 vector out, 3 in service).
  logic [N:0]   m_pend, m_svc;
  logic [N-1:0] m_mask, m_irq_d;
  logic         m_nmi_d;
  int           m_phase, m_win;
  logic [7:0]   exp_q[$];

  function automatic int m_winner();
    if (m_pend[N]) return N;
    for (int i = 0; i < N; i++) if (m_pend[i] && !m_mask[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] vec_of(int w);
    logic [7:0] base;
    base = 8'h20;
    if (w == N) return 8'h02;
    return base + 8'(w);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int         w;
    logic [N:0] nxt;
    if (!rst_n) begin
      m_pend = '0; m_svc = '0; m_mask = '1; m_irq_d = '0; m_nmi_d = 1'b0;
      m_phase = 0; m_win = 0;
      exp_q.delete();
    end else begin
      w   = m_winner();
      nxt = m_pend;
      if (m_phase == 2) nxt[m_win] = 1'b0;
      for (int i = 0; i < N; i++) if (irq[i] && !m_irq_d[i]) nxt[i] = 1'b1;
      if (nmi && !m_nmi_d) nxt[N] = 1'b1;
      case (m_phase)
        0: if (w >= 0) m_phase = 1;
        1: begin
          if (w < 0) m_phase = 0;
          else if (cpu_if.int_ack) begin
            m_win = w;
            exp_q.push_back(vec_of(w));
            m_phase = 2;
          end
        end
        2: begin m_svc[m_win] = 1'b1; m_phase = 3; end
        default: if (cpu_if.eoi) begin m_svc[m_win] = 1'b0; m_phase = 0; end
      endcase
      if (cpu_if.mask_we) m_mask = cpu_if.mask_wdata;
      m_pend  = nxt;
      m_irq_d = irq;
      m_nmi_d = nmi;
    end
  end

  logic chk_en = 1'b0;

  // Cycle monitor: requests and status against the model
  always @(negedge clk) begin
    int w;
    if (chk_en) begin
      w = m_winner();
      chk("int_req", cpu_if.int_req, (m_phase == 1 && w >= 0 && w < N));
      chk("nmi_req", cpu_if.nmi_req, (m_phase == 1 && w == N));
      chk("vector_valid", cpu_if.vector_valid, (m_phase == 2));
      chk("pending", pending, m_pend);
      chk("in_service", in_service, m_svc);
    end
  end

  // Vector monitor: pops the scoreboard whenever a vector is presented
  always @(negedge clk) begin
    logic [7:0] e;
    if (chk_en) begin
      if (cpu_if.vector_valid) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_vector", cpu_if.vector_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_vector", cpu_if.vector, e);
        end
      end else begin
        chk("vector_idle_zero", cpu_if.vector, 8'h00);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req(string name);
    int n;
    n = 0;
    while (!(cpu_if.int_req || cpu_if.nmi_req) && n < 30) begin
      step();
      n++;
    end
    if (n >= 30) chk(name, 1'b0, 1'b1);
  endtask

  task automatic ack_pulse();
    cpu_if.int_ack = 1'b1; step(); cpu_if.int_ack = 1'b0;
  endtask

  task automatic eoi_pulse();
    cpu_if.eoi = 1'b1; step(); cpu_if.eoi = 1'b0;
  endtask

  task automatic set_mask(logic [N-1:0] m);
    cpu_if.mask_we = 1'b1; cpu_if.mask_wdata = m; step(); cpu_if.mask_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; step(); step(); rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; irq = '0; nmi = 1'b0; irq2 = '0; nmi2 = 1'b0;
    cpu_if.mask_we = 1'b0; cpu_if.mask_wdata = '0; cpu_if.int_ack = 1'b0; cpu_if.eoi = 1'b0;
    lvl_if.mask_we = 1'b0; lvl_if.mask_wdata = '0; lvl_if.int_ack = 1'b0; lvl_if.eoi = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk_en = 1'b1;
    chk("reset_pending", pending, '0);
    chk("reset_int_req", cpu_if.int_req, 1'b0);
    step(); step(); rst_n = 1'b1;

    // Single line, fixed latency, vector 0x23
    set_mask('0);
    irq[3] = 1'b1; step(); irq[3] = 1'b0;
    chk("v1_pending3", pending[3], 1'b1);
    chk("v1_no_req_yet", cpu_if.int_req, 1'b0);
    step();
    chk("v1_int_req", cpu_if.int_req, 1'b1);
    ack_pulse();
    chk("v1_vector", cpu_if.vector, 8'h23);
    step();
    chk("v1_pend_cleared", pending[3], 1'b0);
    chk("v1_in_service", in_service[3], 1'b1);
    eoi_pulse();
    chk("v1_eoi_clear", in_service, '0);

    // Higher-priority arrival while requesting
    irq[5] = 1'b1; step(); irq[5] = 1'b0; step();
    irq[1] = 1'b1; step(); irq[1] = 1'b0;
    ack_pulse();
    chk("v2_vector_hi", cpu_if.vector, 8'h21);
    step(); eoi_pulse();
    wait_req("v2_timeout");
    ack_pulse();
    chk("v2_vector_lo", cpu_if.vector, 8'h25);
    step(); eoi_pulse();

    // NMI pre-empts a pending maskable request
    irq[4] = 1'b1; step(); irq[4] = 1'b0; step();
    chk("v3_int_req", cpu_if.int_req, 1'b1);
    nmi = 1'b1; step(); nmi = 1'b0;
    chk("v3_int_dropped", cpu_if.int_req, 1'b0);
    chk("v3_nmi_req", cpu_if.nmi_req, 1'b1);
    ack_pulse();
    chk("v3_vector", cpu_if.vector, 8'h02);
    step();
    chk("v3_in_service_nmi", in_service[N], 1'b1);
    eoi_pulse();
    wait_req("v3_timeout");
    ack_pulse(); step(); eoi_pulse();

    // Masking holds the request off but keeps it pending
    set_mask('1);
    irq[0] = 1'b1; step(); irq[0] = 1'b0; step(); step();
    chk("v4_masked_req", cpu_if.int_req, 1'b0);
    chk("v4_masked_pend", pending[0], 1'b1);
    set_mask('0);
    step();
    chk("v4_unmasked_req", cpu_if.int_req, 1'b1);
    set_mask('1);
    step();
    chk("v4_back_idle", cpu_if.int_req, 1'b0);
    set_mask('0);
    wait_req("v4_timeout");
    ack_pulse(); step(); eoi_pulse();

    // Asynchronous reset mid-vector, line held high across release
    irq[2] = 1'b1; step(); irq[2] = 1'b0;
    wait_req("v5_timeout_a");
    ack_pulse();
    chk("v5_vec_before_reset", cpu_if.vector_valid, 1'b1);
    irq[2] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("v5_rst_vvalid", cpu_if.vector_valid, 1'b0);
    chk("v5_rst_vector", cpu_if.vector, 8'h00);
    chk("v5_rst_in_service", in_service, '0);
    step(); step(); rst_n = 1'b1;
    step(); step();
    chk("v5_mask_ff_pend", pending[2], 1'b1);
    chk("v5_mask_ff_noreq", cpu_if.int_req, 1'b0);
    set_mask('0);
    wait_req("v5_timeout_b");
    ack_pulse();
    chk("v5_vector", cpu_if.vector, 8'h22);
    step(); eoi_pulse();
    repeat (4) step();
    chk("v5_once", cpu_if.int_req, 1'b0);
    irq[2] = 1'b0;

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) irq[i] = ~irq[i];
      nmi = ($urandom_range(39) == 0);
      cpu_if.mask_we    = ($urandom_range(24) == 0);
      cpu_if.mask_wdata = N'($urandom & $urandom);
      if (cpu_if.int_req || cpu_if.nmi_req) cpu_if.int_ack = $urandom_range(1);
      else                                  cpu_if.int_ack = ($urandom_range(19) == 0);
      cpu_if.eoi = ($urandom_range(4) == 0);
      step();
    end
    irq = '0; nmi = 1'b0; cpu_if.mask_we = 1'b0;
    set_mask('0);
    for (int c = 0; c < 300; c++) begin
      cpu_if.int_ack = cpu_if.int_req || cpu_if.nmi_req;
      cpu_if.eoi     = ($urandom_range(2) == 0);
      step();
    end
    cpu_if.int_ack = 1'b0; cpu_if.eoi = 1'b0;
    step(); step();
    chk("sb_drained", exp_q.size(), 0);

    // Level mode with a vector base that wraps
    lvl_if.mask_we = 1'b1; lvl_if.mask_wdata = '0; step(); lvl_if.mask_we = 1'b0;
    irq2[3] = 1'b1; step(); step();
    chk("v6_int_req", lvl_if.int_req, 1'b1);
    lvl_if.int_ack = 1'b1; step(); lvl_if.int_ack = 1'b0;
    chk("v6_vvalid", lvl_if.vector_valid, 1'b1);
    chk("v6_vector_wrap", lvl_if.vector, 8'h01);
    step();
    chk("v6_pend_kept", pending2[3], 1'b1);
    lvl_if.eoi = 1'b1; step(); lvl_if.eoi = 1'b0;
    step();
    chk("v6_rereq", lvl_if.int_req, 1'b1);
    irq2[3] = 1'b0; step(); step();
    chk("v6_dropped", lvl_if.int_req, 1'b0);
    chk("v6_pend_gone", pending2[3], 1'b0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multi_interrupt_controller.md
MULTI_INTERRUPT_CONTROLLER -- requirements
Module: multi_interrupt_controller

Interface
REQ-001 Parameter NUM_IRQ, default 8: number of maskable interrupt lines, range 1..32.
REQ-002 Parameter VEC_W, default 8: vector width.
REQ-003 Parameter VEC_BASE, default 8'h20: vector of irq[0]; irq[i] vectors to VEC_BASE+i.
REQ-004 Parameter NMI_VEC, default 8'h02: vector delivered for NMI.
REQ-005 Parameter EDGE_MODE, default 1: 1 latches rising edges of irq; 0 treats irq as level.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 irq  in  NUM_IRQ  maskable requests; index 0 is highest priority.
REQ-009 nmi  in  1  non-maskable request, always rising-edge latched.
REQ-010 mask_we / mask_wdata  in  1 / NUM_IRQ  mask write; bit=1 disables that line.
REQ-011 int_req  out  1  maskable interrupt request to CPU (INT).
REQ-012 nmi_req  out  1  NMI request to CPU.
REQ-013 int_ack  in  1  CPU acknowledge (INA); one-cycle pulse.
REQ-014 vector / vector_valid  out  VEC_W / 1  vector presented to CPU (INTD), valid one cycle.
REQ-015 eoi  in  1  end-of-interrupt pulse from CPU.
REQ-016 pending / in_service  out  NUM_IRQ+1 each  status; bit NUM_IRQ is NMI.

Function
REQ-017 Edge detect: pending[i] SHALL set at the edge where irq[i]=1 and irq_d[i]=0 (irq_d = previous-cycle sample); nmi likewise into pending[NUM_IRQ].
REQ-018 EDGE_MODE=0: pending[i] for maskable lines SHALL equal the registered irq[i]; no clear on vectoring.
REQ-019 An edge on an already-pending line SHALL be absorbed (no count); an edge on an in-service line SHALL set pending for re-service after eoi.
REQ-020 Mask register updates on mask_we at the clock edge; the new mask applies from the next cycle; masking never clears pending.
REQ-021 Eligible set = pending NMI, else (pending & ~mask); winner = NMI, else lowest eligible index.
REQ-022 FSM states IDLE, REQ, VEC, SERV; Moore outputs.
REQ-023 IDLE: eligible set non-empty -> REQ at next edge.
REQ-024 REQ: nmi_req=1 if winner is NMI, else int_req=1; winner re-evaluated every cycle (later higher-priority or NMI arrival replaces it); eligible set empty -> IDLE with both requests low.
REQ-025 REQ with int_ack=1: latch winner, -> VEC.
REQ-026 VEC (one cycle): vector_valid=1, vector=NMI_VEC or (VEC_BASE+idx) mod 2^VEC_W; clear winner pending (edge mode / NMI); set its in_service bit; -> SERV.
REQ-027 SERV: requests low; eoi=1 clears in_service and -> IDLE; new events keep latching into pending.
REQ-028 int_ack outside REQ and eoi outside SERV SHALL be ignored.
REQ-029 Latency: irq edge sampled at edge k -> pending at k -> int_req high after edge k+1 -> vector_valid the cycle after ack.
REQ-030 vector SHALL read 0 whenever vector_valid=0.

Reset
REQ-031 rst_n=0 asynchronously: state IDLE, pending, in_service, irq_d, nmi_d = 0, mask = all ones, all outputs 0.
REQ-032 A line held high across reset release SHALL register as one rising edge on the first clock edge after release.

Verification
V-1 Reset, write mask=0, pulse irq[3] -> int_req after 2 edges; ack -> vector=8'h23 valid 1 cycle; pending[3] cleared; eoi -> IDLE.
V-2 irq[5] pending, in REQ raise irq[1] before ack -> vector=8'h21; after eoi irq[5] serviced with 8'h25.
V-3 In REQ for irq[4], pulse nmi -> int_req drops, nmi_req rises; ack -> vector=8'h02, in_service[NUM_IRQ]=1.
V-4 Mask=all ones, pulse irq[0] -> no request, pending[0]=1; unmask -> int_req next cycle; mask in REQ -> back to IDLE.
V-5 Assert rst_n=0 in VEC -> outputs zero immediately, mask=FF; irq[2] held high through release -> serviced once.
V-6 EDGE_MODE=0, VEC_BASE=8'hFE, irq[3] level -> vector 8'h01 (wrap); stays requested until irq drops.
